// File: rtl/id_ex_pipe_pkg.sv
// Shared pipeline constants for the ID/EX stage: widths, the NOP encoding and
// the forwarding-unit operand select codes.
package id_ex_pipe_pkg;

  localparam int INS_W        = 32;
  localparam int DEC_W        = 22;
  localparam int DEC_REGWRITE = 21;

  localparam logic [INS_W-1:0] NOP_INS = 32'h00000013;

  localparam logic [2:0] FWD_RF      = 3'd0;
  localparam logic [2:0] FWD_MEM     = 3'd1;
  localparam logic [2:0] FWD_WB_ALU  = 3'd2;
  localparam logic [2:0] FWD_WB_LD   = 3'd3;
  localparam logic [2:0] FWD_TMP_LD  = 3'd4;
  localparam logic [2:0] FWD_TMP_ALU = 3'd5;

endpackage

// File: rtl/id_ex_pipe_fwd_mux.sv
// Six-source operand selector driven by a forwarding code; reserved codes
// fall back to the register-file value.
module fwd_mux
  import id_ex_pipe_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      code,
  input  logic [XLEN-1:0] rf_val,
  input  logic [XLEN-1:0] mem_alu,
  input  logic [XLEN-1:0] wb_alu,
  input  logic [XLEN-1:0] wb_ld,
  input  logic [XLEN-1:0] tmp_ld,
  input  logic [XLEN-1:0] tmp_alu,
  output logic [XLEN-1:0] op_val
);

  always_comb begin
    op_val = rf_val;
    case (code)
      FWD_MEM:     op_val = mem_alu;
      FWD_WB_ALU:  op_val = wb_alu;
      FWD_WB_LD:   op_val = wb_ld;
      FWD_TMP_LD:  op_val = tmp_ld;
      FWD_TMP_ALU: op_val = tmp_alu;
      default:     op_val = rf_val;
    endcase
  end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with EX operand forwarding and the WB_temp register
// that keeps the previous cycle's WB stage visible to the forwarding unit.
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int         XLEN    = 64,
  parameter logic [31:0] NOP_INS = 32'h00000013
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [31:0]     id_ins,
  input  logic [21:0]     id_decode,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic            flush,
  input  logic            stall,
  input  logic [2:0]      forward_signal1,
  input  logic [2:0]      forward_signal2,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [31:0]     wb_ins,
  input  logic [21:0]     wb_decode,
  input  logic [XLEN-1:0] wb_alu_result,
  input  logic [XLEN-1:0] wb_load_data,
  output logic [31:0]     ex_ins,
  output logic [21:0]     ex_decode,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic            ex_bubble,
  output logic            id_hold,
  output logic [31:0]     wb_temp_ins,
  output logic [21:0]     wb_temp_decode,
  output logic [XLEN-1:0] wb_temp_alu,
  output logic [XLEN-1:0] wb_temp_load
);

  localparam int NUM_OPS = 2;

  logic [INS_W-1:0] ex_ins_q, ex_ins_d;
  logic [DEC_W-1:0] ex_decode_q, ex_decode_d;
  logic [XLEN-1:0]  ex_pc_q, ex_pc_d, ex_imm_q, ex_imm_d;
  logic [NUM_OPS-1:0][XLEN-1:0] rs_q, rs_d, op_val;
  logic [NUM_OPS-1:0][2:0]      fwd_code;

  logic [INS_W-1:0] wb_temp_ins_q, wb_temp_ins_d;
  logic [DEC_W-1:0] wb_temp_decode_q, wb_temp_decode_d;
  logic [XLEN-1:0]  wb_temp_alu_q, wb_temp_alu_d, wb_temp_load_q, wb_temp_load_d;

  // Flush outranks stall so a squashed instruction never lingers in EX.
  always_comb begin
    ex_ins_d    = ex_ins_q;
    ex_decode_d = ex_decode_q;
    ex_pc_d     = ex_pc_q;
    ex_imm_d    = ex_imm_q;
    rs_d        = rs_q;
    if (flush) begin
      ex_ins_d    = NOP_INS;
      ex_decode_d = '0;
      ex_pc_d     = '0;
      ex_imm_d    = '0;
      rs_d        = '0;
    end else if (!stall) begin
      ex_ins_d    = id_ins;
      ex_decode_d = id_decode;
      ex_pc_d     = id_pc;
      ex_imm_d    = id_imm;
      rs_d[0]     = id_rs1_data;
      rs_d[1]     = id_rs2_data;
    end
  end

  always_comb begin
    wb_temp_ins_d    = wb_ins;
    wb_temp_decode_d = wb_decode;
    wb_temp_alu_d    = wb_alu_result;
    wb_temp_load_d   = wb_load_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_ins_q         <= NOP_INS;
      ex_decode_q      <= '0;
      ex_pc_q          <= '0;
      ex_imm_q         <= '0;
      rs_q             <= '0;
      wb_temp_ins_q    <= NOP_INS;
      wb_temp_decode_q <= '0;
      wb_temp_alu_q    <= '0;
      wb_temp_load_q   <= '0;
    end else begin
      ex_ins_q         <= ex_ins_d;
      ex_decode_q      <= ex_decode_d;
      ex_pc_q          <= ex_pc_d;
      ex_imm_q         <= ex_imm_d;
      rs_q             <= rs_d;
      wb_temp_ins_q    <= wb_temp_ins_d;
      wb_temp_decode_q <= wb_temp_decode_d;
      wb_temp_alu_q    <= wb_temp_alu_d;
      wb_temp_load_q   <= wb_temp_load_d;
    end
  end

  assign fwd_code[0] = forward_signal1;
  assign fwd_code[1] = forward_signal2;

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    fwd_mux #(.XLEN(XLEN)) u_fwd_mux (
      .code    (fwd_code[g]),
      .rf_val  (rs_q[g]),
      .mem_alu (mem_alu_result),
      .wb_alu  (wb_alu_result),
      .wb_ld   (wb_load_data),
      .tmp_ld  (wb_temp_load_q),
      .tmp_alu (wb_temp_alu_q),
      .op_val  (op_val[g])
    );
  end

  assign ex_ins         = ex_ins_q;
  assign ex_decode      = ex_decode_q;
  assign ex_pc          = ex_pc_q;
  assign ex_imm         = ex_imm_q;
  assign ex_rs1_val     = op_val[0];
  assign ex_rs2_val     = op_val[1];
  assign ex_bubble      = stall;
  assign id_hold        = stall & ~flush;
  assign wb_temp_ins    = wb_temp_ins_q;
  assign wb_temp_decode = wb_temp_decode_q;
  assign wb_temp_alu    = wb_temp_alu_q;
  assign wb_temp_load   = wb_temp_load_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench for id_ex_pipe: reset, stall/flush sequencing, forwarding
// sweeps from a vector table, and WB_temp capture.
`timescale 1ns/1ps
module tb_id_ex_pipe;

  localparam int XLEN = 64;

  logic            clk, rstn;
  logic [31:0]     id_ins, wb_ins;
  logic [21:0]     id_decode, wb_decode;
  logic [XLEN-1:0] id_pc, id_imm, id_rs1_data, id_rs2_data;
  logic            flush, stall;
  logic [2:0]      forward_signal1, forward_signal2;
  logic [XLEN-1:0] mem_alu_result, wb_alu_result, wb_load_data;
  logic [31:0]     ex_ins, wb_temp_ins;
  logic [21:0]     ex_decode, wb_temp_decode;
  logic [XLEN-1:0] ex_pc, ex_imm, ex_rs1_val, ex_rs2_val, wb_temp_alu, wb_temp_load;
  logic            ex_bubble, id_hold;

  int passed = 0;
  int total  = 0;

  id_ex_pipe #(.XLEN(XLEN), .NOP_INS(32'h00000013)) dut (
    .clk(clk), .rstn(rstn),
    .id_ins(id_ins), .id_decode(id_decode), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .flush(flush), .stall(stall),
    .forward_signal1(forward_signal1), .forward_signal2(forward_signal2),
    .mem_alu_result(mem_alu_result),
    .wb_ins(wb_ins), .wb_decode(wb_decode),
    .wb_alu_result(wb_alu_result), .wb_load_data(wb_load_data),
    .ex_ins(ex_ins), .ex_decode(ex_decode), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_bubble(ex_bubble), .id_hold(id_hold),
    .wb_temp_ins(wb_temp_ins), .wb_temp_decode(wb_temp_decode),
    .wb_temp_alu(wb_temp_alu), .wb_temp_load(wb_temp_load)
  );

  initial clk = 0;
  always #50 clk = ~clk;

  typedef struct {
    logic [2:0]      f1;
    logic [2:0]      f2;
    logic [XLEN-1:0] e1;
    logic [XLEN-1:0] e2;
  } fwd_vec_t;

  fwd_vec_t vecs [16];

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rf=1, mem=2, wbalu=3, wbld=4, tmpld=5, tmpalu=6
    for (int i = 0; i < 8; i++) begin
      vecs[i].f1 = 3'(i);
      vecs[i].f2 = 3'd0;
      vecs[i].e2 = 64'd1;
      vecs[8+i].f1 = 3'd1;
      vecs[8+i].f2 = 3'(i);
      vecs[8+i].e1 = 64'd2;
    end
    vecs[0].e1 = 1; vecs[1].e1 = 2; vecs[2].e1 = 3; vecs[3].e1 = 4;
    vecs[4].e1 = 5; vecs[5].e1 = 6; vecs[6].e1 = 1; vecs[7].e1 = 1;
    vecs[8].e2 = 1; vecs[9].e2 = 2; vecs[10].e2 = 3; vecs[11].e2 = 4;
    vecs[12].e2 = 5; vecs[13].e2 = 6; vecs[14].e2 = 1; vecs[15].e2 = 1;

    rstn = 1; flush = 0; stall = 0;
    id_ins = 32'h00500093; id_decode = 22'h200001;
    id_pc = 64'h1000; id_imm = 64'h5;
    id_rs1_data = 64'h11; id_rs2_data = 64'h22;
    forward_signal1 = 0; forward_signal2 = 0;
    mem_alu_result = 0; wb_ins = 32'h00000013; wb_decode = 0;
    wb_alu_result = 0; wb_load_data = 0;
    #1 rstn = 0;
    step(); step();

    chk("rst_ex_ins", 64'(ex_ins), 64'h13);
    chk("rst_ex_decode", 64'(ex_decode), 0);
    chk("rst_ex_pc", ex_pc, 0);
    chk("rst_ex_imm", ex_imm, 0);
    chk("rst_rs1", ex_rs1_val, 0);
    chk("rst_rs2", ex_rs2_val, 0);
    chk("rst_tmp_ins", 64'(wb_temp_ins), 64'h13);
    chk("rst_tmp_alu", wb_temp_alu, 0);
    chk("rst_tmp_load", wb_temp_load, 0);
    chk("rst_bubble0", 64'(ex_bubble), 0);
    stall = 1; #1;
    chk("rst_bubble1", 64'(ex_bubble), 1);
    chk("rst_hold1", 64'(id_hold), 1);
    stall = 0;

    #10 rstn = 1;
    step();
    chk("post_rst_ins", 64'(ex_ins), 64'h00500093);
    chk("post_rst_pc", ex_pc, 64'h1000);
    chk("post_rst_rs1", ex_rs1_val, 64'h11);

    // Two-cycle stall holds ID/EX, including latched register data.
    id_ins = 32'h00A00113; id_pc = 64'h1004; id_rs1_data = 64'h33;
    step();
    chk("ld_ins", 64'(ex_ins), 64'h00A00113);
    stall = 1; id_ins = 32'h00B00193; id_pc = 64'h1008; id_rs1_data = 64'h44;
    #1;
    chk("stall_bubble", 64'(ex_bubble), 1);
    chk("stall_hold", 64'(id_hold), 1);
    step();
    chk("stall1_ins", 64'(ex_ins), 64'h00A00113);
    chk("stall1_pc", ex_pc, 64'h1004);
    id_ins = 32'h00C00213; id_pc = 64'h100C; id_rs1_data = 64'h55;
    step();
    chk("stall2_ins", 64'(ex_ins), 64'h00A00113);
    chk("stall2_pc", ex_pc, 64'h1004);
    chk("stall2_rs1", ex_rs1_val, 64'h33);
    stall = 0;
    step();
    chk("release_ins", 64'(ex_ins), 64'h00C00213);
    chk("release_pc", ex_pc, 64'h100C);

    // Flush wins over stall but the bubble is still raised.
    flush = 1; stall = 1; #1;
    chk("fs_bubble", 64'(ex_bubble), 1);
    chk("fs_hold", 64'(id_hold), 0);
    step();
    chk("fs_ins", 64'(ex_ins), 64'h13);
    chk("fs_decode", 64'(ex_decode), 0);
    chk("fs_pc", ex_pc, 0);
    chk("fs_rs1", ex_rs1_val, 0);
    flush = 0; stall = 0;

    // Forwarding sweep: WB_temp gets load=5, alu=6, then live sources change.
    id_rs1_data = 1; id_rs2_data = 1;
    wb_alu_result = 6; wb_load_data = 5;
    step();
    mem_alu_result = 2; wb_alu_result = 3; wb_load_data = 4;
    for (int i = 0; i < 16; i++) begin
      forward_signal1 = vecs[i].f1;
      forward_signal2 = vecs[i].f2;
      #2;
      chk($sformatf("fwd1_v%0d", i), ex_rs1_val, vecs[i].e1);
      chk($sformatf("fwd2_v%0d", i), ex_rs2_val, vecs[i].e2);
    end

    // WB_temp captures regardless of stall/flush, then is selectable via code 5.
    forward_signal1 = 0; forward_signal2 = 0;
    wb_alu_result = 64'hDEAD; wb_ins = 32'h12345678; wb_decode = 22'h200000;
    stall = 1; flush = 1;
    step();
    chk("tmp_alu_dead", wb_temp_alu, 64'hDEAD);
    chk("tmp_ins", 64'(wb_temp_ins), 64'h12345678);
    chk("tmp_decode", 64'(wb_temp_decode), 64'h200000);
    stall = 0; flush = 0; wb_alu_result = 64'hBEEF;
    forward_signal1 = 3'd5; #1;
    chk("tmp_sel5", ex_rs1_val, 64'hDEAD);
    forward_signal1 = 3'd2; #1;
    chk("wb_sel2", ex_rs1_val, 64'hBEEF);
    forward_signal1 = 0;

    // Asynchronous reset mid-operation, then the first edge loads ID normally.
    id_ins = 32'h00D00293; id_pc = 64'h2000; id_rs1_data = 64'h77;
    step();
    chk("pre_rst_ins", 64'(ex_ins), 64'h00D00293);
    #10 rstn = 0; #1;
    chk("async_rst_ins", 64'(ex_ins), 64'h13);
    chk("async_rst_rs1", ex_rs1_val, 0);
    chk("async_rst_tmp", wb_temp_alu, 0);
    #10 rstn = 1;
    step();
    chk("rerelease_ins", 64'(ex_ins), 64'h00D00293);
    chk("rerelease_rs1", ex_rs1_val, 64'h77);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

ID/EX pipeline register and EX operand-select stage of the 5-stage RV64 core. It sits directly downstream of the forwarding unit. It consumes that unit's `forward_signal1/2` and `stall` to hold or bubble the EX stage and to pick each EX operand from the register file or a later stage. It also owns the WB_temp register that feeds `wb_temp_*` back into the forwarding unit.

## Interface
Parameters:
- `XLEN`, 64, datapath width
- `NOP_INS`, 32'h00000013, instruction loaded on reset, bubble or flush

Ports:
- `clk` in 1: rising-edge clock
- `rstn` in 1: asynchronous, active-low reset
- `id_ins` in 32 / `id_decode` in 22: instruction and control word from ID; `decode[21]` is RegWrite
- `id_pc`, `id_imm`, `id_rs1_data`, `id_rs2_data` in XLEN: ID-stage values
- `flush` in 1: taken branch/jump resolved in EX
- `stall` in 1 / `forward_signal1`, `forward_signal2` in 3: from the forwarding unit
- `mem_alu_result` in XLEN: MEM-stage ALU result
- `wb_ins` in 32 / `wb_decode` in 22 / `wb_alu_result`, `wb_load_data` in XLEN: WB stage
- `ex_ins` out 32 / `ex_decode` out 22 / `ex_pc`, `ex_imm` out XLEN: registered EX contents
- `ex_rs1_val`, `ex_rs2_val` out XLEN: forwarded operands (combinational)
- `ex_bubble` out 1: EX/MEM register must load NOP this cycle
- `id_hold` out 1: PC and IF/ID must hold this cycle
- `wb_temp_ins` out 32 / `wb_temp_decode` out 22 / `wb_temp_alu`, `wb_temp_load` out XLEN: WB_temp register

## Operation
- ID/EX register update priority on each clock edge:
  1. `flush` loads NOP: `ex_ins=NOP_INS`, `ex_decode=0`, all data 0.
  2. Otherwise `stall` holds every ID/EX field, including the latched rs1/rs2 register-file data.
  3. Otherwise all `id_*` fields are loaded.
- `flush` and `stall` together: the flush wins, and `ex_bubble` is still 1 for that cycle.
- `ex_bubble = stall`. `id_hold = stall & ~flush`.
- Operand select, applied independently to rs1 and rs2 against the latched register-file value:
  - 0: register-file value
  - 1: `mem_alu_result`
  - 2: `wb_alu_result`
  - 3: `wb_load_data`
  - 4: `wb_temp_load`
  - 5: `wb_temp_alu`
  - 6 and 7: register-file value (reserved codes)
- WB_temp register: captures `wb_ins`, `wb_decode`, `wb_alu_result` and `wb_load_data` unconditionally every cycle, so it always holds the previous cycle's WB stage. Neither stall nor flush affects it.
- No arithmetic is performed. All muxing is full XLEN width, with no sign or zero extension.

## Timing
- Reset (asynchronous, `rstn=0`):
  - `ex_ins=NOP_INS`, `ex_decode=0`, `ex_pc=ex_imm=0`, latched rs data 0, so `ex_rs1_val=ex_rs2_val=0`.
  - `wb_temp_ins=NOP_INS`, `wb_temp_decode=0`, `wb_temp_alu=wb_temp_load=0`.
  - `ex_bubble` and `id_hold` follow `stall` combinationally.
- Reset deassertion mid-operation: the first edge with `rstn=1` loads the ID values normally. No partial state survives.
- ID→EX latency is 1 cycle. Operand mux latency is 0 cycles from `forward_signal*`.
- Load-use case:
  - Cycle N: `stall=1`; EX holds and a bubble goes to MEM.
  - Cycle N+1: the load is in WB and the forwarding unit issues code 3; EX proceeds.
- An instruction held for 2+ stall cycles reads WB_temp codes 4/5 for producers that have left WB.

## Structure
- Shared pipeline package:
  - `NOP_INS`
  - forward code constants `FWD_RF`, `FWD_MEM`, `FWD_WB_ALU`, `FWD_WB_LD`, `FWD_TMP_LD`, `FWD_TMP_ALU`
  - `DEC_REGWRITE=21`
  - widths `INS_W=32`, `DEC_W=22`
- Sub-module `fwd_mux`: a 6-input XLEN-wide selector with a code input. Instantiate it twice, once for rs1 and once for rs2.

## Test plan
- Reset with `id_ins=32'h00500093` present → `ex_ins=32'h00000013`, `ex_decode=0`, all outputs 0; the first edge after release gives `ex_ins=32'h00500093`.
- `stall=1` for 2 cycles while `id_ins` changes → `ex_ins`/`ex_pc` are unchanged, `ex_bubble=1`, `id_hold=1`; on release the next ID instruction loads.
- `flush=1` and `stall=1` in the same cycle → `ex_ins=NOP_INS`, `ex_decode=0`, `ex_bubble=1`, `id_hold=0`.
- `forward_signal1` swept 0..7 with distinct sources (rf=1, mem=2, wbalu=3, wbld=4, tmpld=5, tmpalu=6) → `ex_rs1_val` = 1,2,3,4,5,6,1,1.
- Same sweep on `forward_signal2` while `forward_signal1=1` → each operand selects independently.
- `wb_alu_result=64'hDEAD` at edge N → `wb_temp_alu=64'hDEAD` after edge N regardless of `stall`/`flush`, and it is selectable through code 5 in cycle N+1.
